// File: rtl/gen_prod.sv
// gen_prod: registered partial-product generator for the 6x6 multiplier datapath.
// Builds the WxW AND array of partial products and the exact product (shift-add
// of the array rows). Both are captured in one pipeline stage that carries a
// valid flag.
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous, active-high reset
//   in_valid  - x/y carry a valid operand pair this cycle
//   x         - multiplicand, unsigned, W bits
//   y         - multiplier, unsigned, W bits
//   P         - flattened partial products; row i (bit y[i]) sits at P[i*W +: W], registered
//   prod      - exact product x*y, 2W bits, registered
//   out_valid - P/prod hold the result of the last accepted operand pair
module gen_prod #(
    parameter int unsigned W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    output logic [W*W-1:0]   P,
    output logic [2*W-1:0]   prod,
    output logic             out_valid
);

    localparam int unsigned PW = W * W;
    localparam int unsigned RW = 2 * W;

    logic [PW-1:0] pp_c;
    logic [RW-1:0] sum_c;

    // AND array: each row is x gated by one multiplier bit
    always_comb begin
        pp_c = '0;
        for (int unsigned i = 0; i < W; i++) begin
            pp_c[i*W +: W] = x & {W{y[i]}};
        end
    end

    // Exact product: add each row shifted by its multiplier-bit weight
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < W; i++) begin
            sum_c = sum_c + (RW'(pp_c[i*W +: W]) << i);
        end
    end

    // Output stage: load on valid input, otherwise hold data and drop valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            P         <= '0;
            prod      <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            P         <= pp_c;
            prod      <= sum_c;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gen_prod.sv
// tb_gen_prod: self-checking bench for gen_prod.
// A behavioural model tracks the expected registered outputs. It builds the
// partial-product bits from their definition and takes the product from plain
// multiplication. Directed cases, an exhaustive stream with a mid-stream reset,
// and a randomized phase are all compared against that model.
module tb_gen_prod;

    localparam int unsigned W  = 6;
    localparam int unsigned PW = W * W;
    localparam int unsigned RW = 2 * W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [PW-1:0] P;
    logic [RW-1:0] prod;
    logic          out_valid;

    int unsigned checks_total;
    int unsigned checks_passed;

    // Expected registered state
    logic [PW-1:0] exp_p;
    logic [RW-1:0] exp_prod;
    logic          exp_valid;

    gen_prod #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .P         (P),
        .prod      (prod),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] model_pp(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < int'(W); i++) begin
            for (int j = 0; j < int'(W); j++) begin
                r[i*int'(W) + j] = b[i] & a[j];
            end
        end
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".P"},         64'(P),         64'(exp_p));
        check({tag, ".prod"},      64'(prod),      64'(exp_prod));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
    endtask

    // Drive one cycle at the falling edge, advance the model on the rising
    // edge, then check just after it.
    task automatic step(input logic iv, input logic [W-1:0] xx, input logic [W-1:0] yy,
                        input string tag);
        @(negedge clk);
        in_valid = iv;
        x        = xx;
        y        = yy;
        @(posedge clk);
        if (rst) begin
            exp_p     = '0;
            exp_prod  = '0;
            exp_valid = 1'b0;
        end else if (iv) begin
            exp_p     = model_pp(xx, yy);
            exp_prod  = RW'(int'(xx) * int'(yy));
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        exp_p         = '0;
        exp_prod      = '0;
        exp_valid     = 1'b0;

        // Reset held with full-scale operands valid: outputs stay clear
        rst      = 1'b1;
        in_valid = 1'b1;
        x        = 6'd63;
        y        = 6'd63;
        #1;
        check_outputs("reset_async");
        for (int k = 0; k < 3; k++) step(1'b1, 6'd63, 6'd63, "reset_clk");
        @(negedge clk);
        rst = 1'b0;

        // Directed boundaries and sparse case
        step(1'b1, 6'd0,  6'd0,  "zero");
        check("zero.P_const", 64'(P), 64'h0);
        step(1'b1, 6'd1,  6'd3,  "sparse");
        check("sparse.P_const", 64'(P), 64'h41);
        check("sparse.prod_const", 64'(prod), 64'd3);
        step(1'b1, 6'd63, 6'd63, "full");
        check("full.P_const", 64'(P), 64'hF_FFFF_FFFF);
        check("full.prod_const", 64'(prod), 64'd3969);
        step(1'b1, 6'd63, 6'd1,  "row0");
        check("row0.P_const", 64'(P), 64'h3F);
        step(1'b1, 6'd0,  6'd63, "x_zero");
        step(1'b1, 6'd63, 6'd0,  "y_zero");

        // Hold: capture 5*7, then idle with changing operands
        step(1'b1, 6'd5, 6'd7, "hold_cap");
        check("hold_cap.prod_const", 64'(prod), 64'd35);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, W'($urandom), W'($urandom), "hold_idle");
            check("hold_idle.prod_const", 64'(prod), 64'd35);
        end

        // Exhaustive stream with an asynchronous reset mid-stream
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                if (a == 32 && b == 17) begin
                    #2;
                    rst = 1'b1;
                    #1;
                    exp_p     = '0;
                    exp_prod  = '0;
                    exp_valid = 1'b0;
                    check_outputs("midstream_rst");
                    step(1'b1, W'(a), W'(b), "midstream_rst_clk");
                    @(negedge clk);
                    rst = 1'b0;
                end
                step(1'b1, W'(a), W'(b), "exhaustive");
            end
        end

        // Randomized valid pattern and operands
        for (int k = 0; k < 300; k++) begin
            step(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), "random");
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/gen_prod.md
Name: gen_prod

Overview:
- Registered partial-product generator for the 6x6 approximate multiplier datapath.
- Takes two 6-bit unsigned operands and produces the full 6x6 AND-array of partial-product bits as a flattened 36-bit bus for the downstream compressor/accumulation tree.
- Also produces the exact 12-bit product, summed from its own partial products, as a golden reference for error measurement of the approximate tree.
- Single pipeline stage with a valid qualifier.

Parameters:
- W, 6, operand width. The design is verified only at 6; generic code is encouraged.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands on x/y are valid this cycle.
- x  input  6  multiplicand, unsigned.
- y  input  6  multiplier, unsigned.
- P  output  36  flattened partial-product array, registered.
- prod  output  12  exact product x*y, registered.
- out_valid  output  1  P/prod hold a valid result.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Partial-product definition: P[i*6+j] = y[i] & x[j], for i,j in 0..5.
  - Row i corresponds to multiplier bit y[i].
  - Column j corresponds to multiplicand bit x[j].
  - Bit weight is 2^(i+j).
  - Row i occupies P[i*6+5 : i*6].
- Exact product: prod = sum over i,j of P-bit(i,j) << (i+j).
  - Computed combinationally from the same AND array, not with a * operator, as an explicit shift-add of the 6 rows.
  - Zero-extended to 12 bits. No overflow is possible: max 63*63 = 3969 < 4096.
- Pipeline, latency 1 cycle:
  - On a rising clk with in_valid=1, P and prod load the results for the current x,y and out_valid <= 1.
  - With in_valid=0, P and prod hold their previous values and out_valid <= 0.
- No backpressure; a new operand pair is accepted every cycle.
- Reset:
  - While rst=1, P=0, prod=0, out_valid=0 immediately, regardless of clk.
  - Reset asserted mid-stream discards the in-flight result.
  - The first capture after release occurs on the first rising clk with rst=0 and in_valid=1.
- X handling: none. Inputs are required to be known whenever in_valid=1.
- Boundaries:
  - x=0 or y=0 gives all-zero P and prod=0.
  - x=y=63 gives P all ones and prod=3969.
- The output is fully unsigned. No sign extension or Baugh-Wooley inversion.

Test Plan:
- Reset: assert rst with x=y=63 and in_valid=1, then toggle clk -> P=0, prod=0, out_valid=0 throughout; asynchronous clear is visible before any clock edge.
- Zero operands: x=0, y=0, in_valid=1, one clk -> P=36'h0, prod=0, out_valid=1.
- Sparse: x=6'b000001, y=6'b000011 -> only P[0] and P[6] are 1, prod=3, result one cycle after capture.
- Full scale: x=63, y=63 -> P=36'hF_FFFF_FFFF, prod=3969. Also x=63, y=1 -> P=36'h3F (row 0 only), prod=63.
- Hold/valid: capture x=5, y=7 (prod=35), then drop in_valid for 3 cycles while changing x/y -> P/prod stay at the x=5, y=7 values, out_valid=0.
- Exhaustive: all 4096 operand pairs streamed back-to-back, then reset asserted mid-stream -> every result equals the bitwise AND model and x*y with 1-cycle latency; outputs clear on rst, and streaming resumes correctly after release.
